// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle WIDTH-bit adder that adds CHUNK bits per clock,
// rippling the carry between chunks through a carry register.
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   start         - request; accepted in IDLE or DONE
//   a, b, cin     - operands and carry-in, registered on an accepted start
//   busy          - high while chunks are being added (RUN)
//   done          - one-cycle pulse when sum/overflow are updated
//   sum           - {carry_out, a+b+cin}, held until the next done
//   overflow      - two's-complement overflow of the last result
module seq_chunk_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum,
  output logic             overflow
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned RW     = CHUNK + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic [RW-1:0]    chunk_res;
  logic             msb_cin;

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    a_chunk = '0;
    b_chunk = '0;

    // Select the chunk addressed by the counter
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (cnt_q == CW'(i)) begin
        a_chunk = a_q[i*CHUNK +: CHUNK];
        b_chunk = b_q[i*CHUNK +: CHUNK];
      end
    end

    chunk_res = {1'b0, a_chunk} + {1'b0, b_chunk} + RW'(carry_q);
    // Carry into the chunk MSB recovered from the sum bit: s = a ^ b ^ c
    msb_cin   = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_res[CHUNK-1];

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        for (int unsigned i = 0; i < NCHUNK; i++) begin
          if (cnt_q == CW'(i)) begin
            acc_d[i*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
          end
        end
        carry_d = chunk_res[CHUNK];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(NCHUNK - 1)) begin
          sum_d   = {chunk_res[CHUNK], acc_d};
          ovf_d   = msb_cin ^ chunk_res[CHUNK];
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Testbench for seq_chunk_adder: five configurations, scoreboard of expected
// results keyed by instance, directed steps followed by a random sweep.
module tb_seq_chunk_adder;

  localparam int NDUT = 5;

  function automatic int unsigned w_of(input int g);
    case (g)
      0: return 16;
      1: return 4;
      2: return 8;
      3: return 32;
      default: return 12;
    endcase
  endfunction

  function automatic int unsigned c_of(input int g);
    case (g)
      0: return 4;
      1: return 4;
      2: return 2;
      3: return 8;
      default: return 12;
    endcase
  endfunction

  function automatic int nchunk(input int g);
    return int'(w_of(g) / c_of(g));
  endfunction

  typedef struct {
    int          id;
    logic [32:0] sum;
    logic        ovf;
    int          due;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start_s [NDUT];
  logic [31:0] a_s     [NDUT];
  logic [31:0] b_s     [NDUT];
  logic        cin_s   [NDUT];
  logic        busy_w  [NDUT];
  logic        done_w  [NDUT];
  logic        ovf_w   [NDUT];
  logic [32:0] sum_w   [NDUT];

  exp_t        sb[$];
  logic [32:0] hold_sum [NDUT];
  logic        hold_ovf [NDUT];
  int          checks;
  int          failures;
  int          cyc;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned W = w_of(g);
    localparam int unsigned C = c_of(g);
    logic         busy_v, done_v, ovf_v;
    logic [W:0]   sum_v;
    seq_chunk_adder #(.WIDTH(W), .CHUNK(C)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start_s[g]),
      .a        (a_s[g][W-1:0]),
      .b        (b_s[g][W-1:0]),
      .cin      (cin_s[g]),
      .busy     (busy_v),
      .done     (done_v),
      .sum      (sum_v),
      .overflow (ovf_v)
    );
    assign busy_w[g] = busy_v;
    assign done_w[g] = done_v;
    assign ovf_w[g]  = ovf_v;
    assign sum_w[g]  = 33'(sum_v);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: plain wide addition, sign-rule overflow
  function automatic exp_t model(input int g, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin);
    exp_t        e;
    int unsigned w;
    logic [63:0] m, aa, bb, s;
    w  = w_of(g);
    m  = (64'd1 << w) - 64'd1;
    aa = 64'(a) & m;
    bb = 64'(b) & m;
    s  = aa + bb + 64'(cin);
    e.id  = g;
    e.sum = 33'(s);
    e.ovf = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
    e.due = cyc + 1 + nchunk(g);
    return e;
  endfunction

  // Drives one accepted request on instance g; returns one cycle later
  task automatic issue(input int g, input logic [31:0] a, input logic [31:0] b, input logic cin);
    @(negedge clk);
    start_s[g] = 1'b1;
    a_s[g]     = a;
    b_s[g]     = b;
    cin_s[g]   = cin;
    sb.push_back(model(g, a, b, cin));
    @(negedge clk);
    start_s[g] = 1'b0;
    a_s[g]     = $urandom;
    b_s[g]     = $urandom;
    cin_s[g]   = 1'($urandom_range(0, 1));
  endtask

  // Output monitor: pops the scoreboard on done, checks hold behaviour otherwise
  int   mon_idx;
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      for (int g = 0; g < NDUT; g++) begin
        chk($sformatf("busy_done_excl[%0d]", g), 64'(busy_w[g] & done_w[g]), 64'd0);
        if (done_w[g]) begin
          mon_idx = -1;
          foreach (sb[i]) if (mon_idx < 0 && sb[i].id == g) mon_idx = i;
          if (mon_idx < 0) begin
            chk($sformatf("spurious_done[%0d]", g), 64'(done_w[g]), 64'd0);
          end else begin
            mon_e = sb[mon_idx];
            sb.delete(mon_idx);
            chk($sformatf("sum[%0d]", g), 64'(sum_w[g]), 64'(mon_e.sum));
            chk($sformatf("ovf[%0d]", g), 64'(ovf_w[g]), 64'(mon_e.ovf));
            chk($sformatf("latency[%0d]", g), 64'(cyc), 64'(mon_e.due));
            hold_sum[g] = mon_e.sum;
            hold_ovf[g] = mon_e.ovf;
          end
        end else begin
          chk($sformatf("sum_hold[%0d]", g), 64'(sum_w[g]), 64'(hold_sum[g]));
          chk($sformatf("ovf_hold[%0d]", g), 64'(ovf_w[g]), 64'(hold_ovf[g]));
        end
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    rst      = 1'b1;
    for (int g = 0; g < NDUT; g++) begin
      start_s[g]  = 1'b0;
      a_s[g]      = '0;
      b_s[g]      = '0;
      cin_s[g]    = 1'b0;
      hold_sum[g] = '0;
      hold_ovf[g] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < NDUT; g++) begin
      chk("reset_busy", 64'(busy_w[g]), 64'd0);
      chk("reset_done", 64'(done_w[g]), 64'd0);
      chk("reset_sum",  64'(sum_w[g]),  64'd0);
      chk("reset_ovf",  64'(ovf_w[g]),  64'd0);
    end
    rst = 1'b0;

    // Single-chunk instance, latency 2
    issue(1, 32'hA, 32'h5, 1'b0);
    @(negedge clk);
    chk("t1a_done", 64'(done_w[1]), 64'd1);
    chk("t1a_sum",  64'(sum_w[1]),  64'h0F);
    chk("t1a_ovf",  64'(ovf_w[1]),  64'd0);
    issue(1, 32'h4, 32'h8, 1'b0);
    @(negedge clk);
    chk("t1b_sum",  64'(sum_w[1]),  64'h0C);
    chk("t1b_ovf",  64'(ovf_w[1]),  64'd0);

    // Carry ripples through all four chunks; busy window then done
    issue(0, 32'hFFFF, 32'h0001, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk("t2_busy", 64'(busy_w[0]), 64'd1);
      chk("t2_nodone", 64'(done_w[0]), 64'd0);
      @(negedge clk);
    end
    chk("t2_done", 64'(done_w[0]), 64'd1);
    chk("t2_busy_off", 64'(busy_w[0]), 64'd0);
    chk("t2_sum", 64'(sum_w[0]), 64'h10000);
    chk("t2_ovf", 64'(ovf_w[0]), 64'd0);
    @(negedge clk);
    chk("t2_done_pulse", 64'(done_w[0]), 64'd0);

    // Signed overflow cases
    issue(0, 32'h7FFF, 32'h0001, 1'b0);
    repeat (4) @(negedge clk);
    chk("t3a_sum", 64'(sum_w[0]), 64'h08000);
    chk("t3a_ovf", 64'(ovf_w[0]), 64'd1);
    issue(0, 32'h8000, 32'h8000, 1'b1);
    repeat (4) @(negedge clk);
    chk("t3b_sum", 64'(sum_w[0]), 64'h10001);
    chk("t3b_ovf", 64'(ovf_w[0]), 64'd1);

    // start while busy is ignored; start in DONE is accepted back-to-back
    issue(0, 32'h1234, 32'h1111, 1'b0);
    @(negedge clk);
    start_s[0] = 1'b1;
    a_s[0]     = 32'hFFFF;
    b_s[0]     = 32'hFFFF;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("t4_done1", 64'(done_w[0]), 64'd1);
    chk("t4_sum1",  64'(sum_w[0]),  64'h02345);
    start_s[0] = 1'b1;
    a_s[0]     = 32'h0F0F;
    b_s[0]     = 32'h00F1;
    cin_s[0]   = 1'b1;
    sb.push_back(model(0, 32'h0F0F, 32'h00F1, 1'b1));
    @(negedge clk);
    start_s[0] = 1'b0;
    a_s[0]     = $urandom;
    b_s[0]     = $urandom;
    repeat (3) @(negedge clk);
    chk("t4_nodone", 64'(done_w[0]), 64'd0);
    @(negedge clk);
    chk("t4_done2", 64'(done_w[0]), 64'd1);
    chk("t4_sum2",  64'(sum_w[0]),  64'h01001);

    // Reset mid-RUN discards the operation
    issue(0, 32'hAAAA, 32'h5555, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    for (int g = 0; g < NDUT; g++) begin
      hold_sum[g] = '0;
      hold_ovf[g] = 1'b0;
    end
    @(negedge clk);
    rst = 1'b0;
    chk("t5_busy", 64'(busy_w[0]), 64'd0);
    chk("t5_done", 64'(done_w[0]), 64'd0);
    chk("t5_sum",  64'(sum_w[0]),  64'd0);
    chk("t5_ovf",  64'(ovf_w[0]),  64'd0);
    repeat (8) @(negedge clk);
    issue(0, 32'h0001, 32'h0002, 1'b0);
    repeat (4) @(negedge clk);
    chk("t5_sum_after", 64'(sum_w[0]), 64'h3);

    // All-ones corner plus random sweep on every configuration
    for (int g = 0; g < NDUT; g++) begin
      issue(g, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      repeat (nchunk(g)) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        issue(g, $urandom, $urandom, 1'($urandom_range(0, 1)));
        repeat (nchunk(g)) @(negedge clk);
      end
    end

    repeat (6) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
